uart_rx_core: RTL and testbench
===============================

UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning data bits per frame.
REQ-003 SHALL have port S_AXI_ACLK  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port S_AXI_ARESETN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port BAUD_RATE  input  32  baud rate in bit/s, from the register block.
REQ-006 SHALL have port UART_RX  input  1  serial line, asynchronous to the clock, idle high.
REQ-007 SHALL have port RX_DATA  output  DATA_WIDTH  last good received byte.
REQ-008 SHALL have port RX_DONE  output  1  one-cycle pulse when RX_DATA updates.
REQ-009 SHALL have port RX_BUSY  output  1  high whenever the FSM is not IDLE.
REQ-010 SHALL have port FRAME_ERR  output  1  one-cycle pulse on bad stop bit.
REQ-011 SHALL have port PARITY_ERR  output  1  one-cycle pulse on parity mismatch.

Function
REQ-012 SHALL pass UART_RX through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-013 SHALL generate 16x oversample ticks by NCO: each cycle acc += BAUD_RATE*16; when acc >= CLK_FREQ, subtract CLK_FREQ and tick; no divider.
REQ-014 SHALL use an accumulator of at least 37 bits; BAUD_RATE*16 >= CLK_FREQ means a tick every cycle; BAUD_RATE=0 means no ticks.
REQ-015 SHALL latch BAUD_RATE and clear acc and tick counter on start detection; BAUD_RATE changes mid-frame have no effect.
REQ-016 SHALL use FSM states IDLE, START, DATA, PARITY (macro only), and STOP.
REQ-017 IDLE SHALL move to START only on a synchronized falling edge: previous 1, current 0.
REQ-018 START SHALL resample on tick 8; low -> DATA; high -> IDLE as a glitch, with no outputs pulsed.
REQ-019 DATA SHALL sample every 16 ticks, LSB first, for DATA_WIDTH bits, then go to PARITY or STOP.
REQ-020 STOP SHALL sample after 16 ticks; high -> RX_DATA updated and RX_DONE pulsed next cycle; low -> FRAME_ERR pulsed and RX_DATA unchanged; both then go to IDLE.
REQ-021 RX_DONE and FRAME_ERR SHALL be mutually exclusive, with at most one pulse per frame.
REQ-022 A start edge occurring in the cycle of the return to IDLE SHALL be detected; back-to-back frames lose nothing.
REQ-023 BAUD_RATE=0 SHALL leave the FSM stalled in its current state until reset or a nonzero rate is latched.

Reset
REQ-024 S_AXI_ARESETN low SHALL immediately set FSM IDLE, acc 0, tick and bit counters 0, shift register 0, and synchronizer flops 1.
REQ-025 Reset outputs SHALL be RX_DATA 0, RX_DONE 0, RX_BUSY 0, FRAME_ERR 0, and PARITY_ERR 0.
REQ-026 Reset mid-frame SHALL abort the frame with no pulse; the next falling edge after release starts a fresh frame.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined SHALL add the PARITY state, one even-parity bit sampled like a data bit.
REQ-028 With UART_RX_PARITY_EN, a mismatch SHALL pulse PARITY_ERR in the same cycle as RX_DONE, and data SHALL still be delivered.
REQ-029 Without UART_RX_PARITY_EN, the frame SHALL be 8N1 style with no PARITY state, and PARITY_ERR SHALL be tied 0.

Structure
REQ-030 Package uart_pkg SHALL hold the rx state enum, OVERSAMPLE=16, MID_TICK=8, and the accumulator width constant.
REQ-031 The NCO tick generator SHALL be sub-module uart_baud_nco, with inputs clk, rst_n, clear, and rate, and output tick.

Verification
REQ-032 CLK_FREQ 100 MHz, BAUD_RATE 115200, frame 0xA5 -> exactly one RX_DONE, RX_DATA=0xA5, and RX_BUSY high for ~10 bit times.
REQ-033 UART_RX low for 3 cycles then high -> START aborts, RX_BUSY returns 0, and no RX_DONE or FRAME_ERR.
REQ-034 Frame 0x3C with stop bit 0 -> FRAME_ERR one pulse, RX_DATA keeps the prior value, and no RX_DONE.
REQ-035 Frames 0x00, 0xFF, 0x55 with zero idle gap -> three RX_DONE pulses with matching RX_DATA.
REQ-036 S_AXI_ARESETN asserted during bit 4 of 0x81, then frame 0x42 -> no pulse for 0x81, and RX_DATA=0x42.
REQ-037 With UART_RX_PARITY_EN, 0x01 sent with parity bit 0 -> RX_DONE and PARITY_ERR in the same cycle, RX_DATA=0x01.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// UART_RX_PARITY_EN adds the PARITY state to the rx state enum.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 8;
    localparam int ACC_W      = 40;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef UART_RX_PARITY_EN
        , PARITY
`endif
    } rx_state_e;

endpackage

// File: rtl/uart_baud_nco.sv
// 16x oversample tick generator: phase accumulator adds rate*16 each cycle and
// wraps at CLK_FREQ, giving a fractional-rate tick without a divider.
module uart_baud_nco
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic [31:0] rate,
    output logic        tick
);

    localparam logic [ACC_W-1:0] FREQ = ACC_W'(CLK_FREQ);

    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] sum;
    logic             tick_reg;
    logic             tick_next;

    assign inc  = ACC_W'(rate) << 4;
    assign sum  = acc_reg + inc;
    assign tick = tick_reg;

    always_comb begin
        acc_next  = acc_reg;
        tick_next = 1'b0;
        if (clear) begin
            acc_next = '0;
        end else if (inc >= FREQ) begin
            // Oversample rate at or above the clock: saturate to a tick every cycle.
            acc_next  = '0;
            tick_next = 1'b1;
        end else if (sum >= FREQ) begin
            acc_next  = sum - FREQ;
            tick_next = 1'b1;
        end else begin
            acc_next = sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg  <= '0;
            tick_reg <= 1'b0;
        end else begin
            acc_reg  <= acc_next;
            tick_reg <= tick_next;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver core: 16x oversampled, LSB first, one stop bit.
// Define UART_RX_PARITY_EN to add an even-parity bit ahead of the stop bit.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int          DATA_WIDTH = 8
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic [31:0]           BAUD_RATE,
    input  logic                  UART_RX,
    output logic [DATA_WIDTH-1:0] RX_DATA,
    output logic                  RX_DONE,
    output logic                  RX_BUSY,
    output logic                  FRAME_ERR,
    output logic                  PARITY_ERR
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    rx_state_e             state_reg, state_next;
    logic                  sync1_reg, sync2_reg, prev_reg;
    logic [TW-1:0]         tick_cnt_reg, tick_cnt_next;
    logic [BW-1:0]         bit_cnt_reg, bit_cnt_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [DATA_WIDTH-1:0] rx_data_reg, rx_data_next;
    logic [31:0]           baud_reg, baud_next;
    logic                  rx_done_reg, rx_done_next;
    logic                  frame_err_reg, frame_err_next;
    logic                  rx_s, rx_fall, tick, tick_last, tick_mid;
    logic                  nco_clear, stop_end;
`ifdef UART_RX_PARITY_EN
    logic                  par_bad_reg, par_bad_next;
    logic                  parity_err_reg, parity_err_next;
`endif

    assign rx_s      = sync2_reg;
    assign rx_fall   = prev_reg & ~sync2_reg;
    assign tick_last = (tick_cnt_reg == TW'(OVERSAMPLE - 1));
    assign tick_mid  = (tick_cnt_reg == TW'(MID_TICK - 1));

    uart_baud_nco #(
        .CLK_FREQ(CLK_FREQ)
    ) u_nco (
        .clk  (S_AXI_ACLK),
        .rst_n(S_AXI_ARESETN),
        .clear(nco_clear),
        .rate (baud_reg),
        .tick (tick)
    );

    always_comb begin
        state_next     = state_reg;
        tick_cnt_next  = tick_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        baud_next      = baud_reg;
        rx_data_next   = rx_data_reg;
        rx_done_next   = 1'b0;
        frame_err_next = 1'b0;
        nco_clear      = 1'b0;
        stop_end       = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_next    = par_bad_reg;
        parity_err_next = 1'b0;
`endif
        case (state_reg)
            IDLE: ;
            START: begin
                if (tick) begin
                    if (tick_mid) begin
                        tick_cnt_next = '0;
                        bit_cnt_next  = '0;
                        state_next    = rx_s ? IDLE : DATA;
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_last) begin
                        shift_next    = {rx_s, shift_reg[DATA_WIDTH-1:1]};
                        tick_cnt_next = '0;
                        bit_cnt_next  = bit_cnt_reg + BW'(1);
                        if (bit_cnt_reg == BW'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (tick_last) begin
                        par_bad_next  = ^{shift_reg, rx_s};
                        tick_cnt_next = '0;
                        state_next    = STOP;
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (tick_last) begin
                        stop_end      = 1'b1;
                        tick_cnt_next = '0;
                        state_next    = IDLE;
                        if (rx_s) begin
                            rx_data_next = shift_reg;
                            rx_done_next = 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err_next = par_bad_reg;
`endif
                        end else begin
                            frame_err_next = 1'b1;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A start edge coinciding with the end of the previous frame is taken directly.
        if (rx_fall && (state_reg == IDLE || stop_end)) begin
            state_next    = START;
            baud_next     = BAUD_RATE;
            nco_clear     = 1'b1;
            tick_cnt_next = '0;
            bit_cnt_next  = '0;
            shift_next    = '0;
`ifdef UART_RX_PARITY_EN
            par_bad_next  = 1'b0;
`endif
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_reg     <= IDLE;
            sync1_reg     <= 1'b1;
            sync2_reg     <= 1'b1;
            prev_reg      <= 1'b1;
            tick_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            rx_data_reg   <= '0;
            baud_reg      <= '0;
            rx_done_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sync1_reg     <= UART_RX;
            sync2_reg     <= sync1_reg;
            prev_reg      <= sync2_reg;
            tick_cnt_reg  <= tick_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            rx_data_reg   <= rx_data_next;
            baud_reg      <= baud_next;
            rx_done_reg   <= rx_done_next;
            frame_err_reg <= frame_err_next;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            par_bad_reg    <= 1'b0;
            parity_err_reg <= 1'b0;
        end else begin
            par_bad_reg    <= par_bad_next;
            parity_err_reg <= parity_err_next;
        end
    end
    assign PARITY_ERR = parity_err_reg;
`else
    assign PARITY_ERR = 1'b0;
`endif

    assign RX_DATA   = rx_data_reg;
    assign RX_DONE   = rx_done_reg;
    assign FRAME_ERR = frame_err_reg;
    assign RX_BUSY   = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: stimulus pushes expected events, a monitor
// pops them on every RX_DONE / FRAME_ERR / PARITY_ERR pulse.
module tb_uart_rx_core;

    localparam int unsigned CLK_FREQ = 100_000_000;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int BC_SLOW = 868;   // cycles per bit at 115200
    localparam int BC_FAST = 100;   // cycles per bit at 1 Mbit/s

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        bit         perr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] BAUD_RATE;
    logic        UART_RX;
    logic [7:0]  RX_DATA;
    logic        RX_DONE;
    logic        RX_BUSY;
    logic        FRAME_ERR;
    logic        PARITY_ERR;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   busy_n = 0;

    always #5 clk = ~clk;

    uart_rx_core #(
        .CLK_FREQ  (CLK_FREQ),
        .DATA_WIDTH(8)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .BAUD_RATE    (BAUD_RATE),
        .UART_RX      (UART_RX),
        .RX_DATA      (RX_DATA),
        .RX_DONE      (RX_DONE),
        .RX_BUSY      (RX_BUSY),
        .FRAME_ERR    (FRAME_ERR),
        .PARITY_ERR   (PARITY_ERR)
    );

    function automatic void push_exp(input bit is_err, input logic [7:0] d, input bit pe);
        exp_t e;
        e.is_err = is_err;
        e.data   = d;
        e.perr   = pe;
        exp_q.push_back(e);
    endfunction

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit par_bad, input int bc);
        UART_RX = 1'b0;
        repeat (bc) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            UART_RX = d[i];
            repeat (bc) @(posedge clk);
        end
`ifdef UART_RX_PARITY_EN
        UART_RX = (^d) ^ par_bad;
        repeat (bc) @(posedge clk);
`endif
        UART_RX = stop_bit;
        repeat (bc) @(posedge clk);
        UART_RX = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s missing_pulse actual=%0d_pending required=0_pending", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every output pulse must match the oldest expected event.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (RX_DONE || FRAME_ERR || PARITY_ERR) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse actual done=%0b ferr=%0b perr=%0b data=0x%02h required no_pulse",
                             RX_DONE, FRAME_ERR, PARITY_ERR, RX_DATA);
                end else begin
                    e = exp_q.pop_front();
                    if (RX_DONE !== !e.is_err || FRAME_ERR !== e.is_err ||
                        PARITY_ERR !== e.perr || RX_DATA !== e.data) begin
                        errors++;
                        $display("FAIL event actual done=%0b ferr=%0b perr=%0b data=0x%02h required done=%0b ferr=%0b perr=%0b data=0x%02h",
                                 RX_DONE, FRAME_ERR, PARITY_ERR, RX_DATA, !e.is_err, e.is_err, e.perr, e.data);
                    end else begin
                        $display("ok   event done=%0b ferr=%0b perr=%0b data=0x%02h", RX_DONE, FRAME_ERR, PARITY_ERR, RX_DATA);
                    end
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        UART_RX   = 1'b1;
        BAUD_RATE = 32'd115200;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check1("reset_rx_data", 32'(RX_DATA), 32'h0);
        check1("reset_rx_done", 32'(RX_DONE), 32'h0);
        check1("reset_rx_busy", 32'(RX_BUSY), 32'h0);
        check1("reset_frame_err", 32'(FRAME_ERR), 32'h0);
        check1("reset_parity_err", 32'(PARITY_ERR), 32'h0);
        @(posedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);

        // 0xA5 at 115200; a mid-frame rate change must not disturb it.
        push_exp(1'b0, 8'hA5, 1'b0);
        fork
            send_frame(8'hA5, 1'b1, 1'b0, BC_SLOW);
            begin
                repeat (2000) @(posedge clk);
                BAUD_RATE = 32'd1_000_000;
            end
            begin
                for (int i = 0; i < FRAME_BITS * BC_SLOW + 100; i++) begin
                    @(negedge clk);
                    if (RX_BUSY) busy_n++;
                end
            end
        join
        checks++;
        if (busy_n < (FRAME_BITS - 1) * BC_SLOW || busy_n > FRAME_BITS * BC_SLOW) begin
            errors++;
            $display("FAIL busy_duration actual=%0d required=%0d..%0d", busy_n,
                     (FRAME_BITS - 1) * BC_SLOW, FRAME_BITS * BC_SLOW);
        end else begin
            $display("ok   busy_duration = %0d cycles", busy_n);
        end
        wait_drain("frame_a5", 2000);

        // Three-cycle glitch: START entered, then aborted silently.
        @(posedge clk);
        UART_RX = 1'b0;
        repeat (3) @(posedge clk);
        UART_RX = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check1("glitch_busy_high", 32'(RX_BUSY), 32'h1);
        repeat (200) @(posedge clk);
        @(negedge clk);
        check1("glitch_busy_low", 32'(RX_BUSY), 32'h0);

        // Bad stop bit: FRAME_ERR only, RX_DATA keeps 0xA5.
        push_exp(1'b1, 8'hA5, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, BC_FAST);
        repeat (200) @(posedge clk);
        wait_drain("frame_3c_err", 500);
        @(negedge clk);
        check1("ferr_data_held", 32'(RX_DATA), 32'hA5);

        // Back-to-back frames with zero idle gap.
        push_exp(1'b0, 8'h00, 1'b0);
        push_exp(1'b0, 8'hFF, 1'b0);
        push_exp(1'b0, 8'h55, 1'b0);
        send_frame(8'h00, 1'b1, 1'b0, BC_FAST);
        send_frame(8'hFF, 1'b1, 1'b0, BC_FAST);
        send_frame(8'h55, 1'b1, 1'b0, BC_FAST);
        repeat (100) @(posedge clk);
        wait_drain("back_to_back", 500);

`ifdef UART_RX_PARITY_EN
        push_exp(1'b0, 8'h01, 1'b1);
        send_frame(8'h01, 1'b1, 1'b1, BC_FAST);
        repeat (100) @(posedge clk);
        wait_drain("parity_bad", 500);
`endif

        // Zero rate: stalls in START until reset.
        BAUD_RATE = 32'd0;
        UART_RX   = 1'b0;
        repeat (300) @(posedge clk);
        @(negedge clk);
        check1("stall_busy_low_line", 32'(RX_BUSY), 32'h1);
        UART_RX   = 1'b1;
        BAUD_RATE = 32'd1_000_000;
        repeat (300) @(posedge clk);
        @(negedge clk);
        check1("stall_busy_persist", 32'(RX_BUSY), 32'h1);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("stall_reset_busy", 32'(RX_BUSY), 32'h0);
        check1("reset_clears_data", 32'(RX_DATA), 32'h0);
        @(posedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);

        // Reset during bit 4 of 0x81 aborts it; 0x42 then arrives intact.
        UART_RX = 1'b0;
        repeat (BC_FAST) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            UART_RX = ((8'h81 >> i) & 8'h01) != 0;
            repeat (BC_FAST) @(posedge clk);
        end
        UART_RX = 1'b0;
        repeat (BC_FAST / 2) @(posedge clk);
        check1("pre_abort_busy", 32'(RX_BUSY), 32'h1);
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check1("abort_busy", 32'(RX_BUSY), 32'h0);
        UART_RX = 1'b1;
        repeat (5) @(posedge clk);
        rst_n = 1'b1;
        repeat (2 * BC_FAST) @(posedge clk);
        push_exp(1'b0, 8'h42, 1'b0);
        send_frame(8'h42, 1'b1, 1'b0, BC_FAST);
        repeat (100) @(posedge clk);
        wait_drain("frame_42", 500);
        @(negedge clk);
        check1("final_rx_data", 32'(RX_DATA), 32'h42);

        repeat (10) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
